// File: rtl/cruise_ctrl_fsm.sv
// Cruise control sequencer: OFF/READY/CRUISE/STANDBY FSM that holds a target speed and
// emits tick-paced up/down count pulses to a downstream speed counter. Macro CRUISE_RESUME_EN enables resume.
module cruise_ctrl_fsm #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cruise_btn,
    input  logic       set_btn,
    input  logic       resume_btn,
    input  logic       accel,
    input  logic       coast,
    input  logic       brake,
    input  logic [2:0] speed,
    output logic       enable,
    output logic       mode,
    output logic [1:0] state,
    output logic [2:0] target
);

    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_READY   = 2'b01,
        ST_CRUISE  = 2'b10,
        ST_STANDBY = 2'b11
    } state_t;

`ifdef CRUISE_RESUME_EN
    localparam bit RESUME_EN = 1'b1;
`else
    localparam bit RESUME_EN = 1'b0;
`endif

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_t     state_q, state_d;
    logic [2:0] target_q, target_d;
    logic       valid_q, valid_d;
    logic       enable_q, enable_d;
    logic       mode_q, mode_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic       cruise_q, set_q, resume_q;
    logic       arm_q;

    logic tick;
    logic cruise_ev, set_ev, resume_ev;

    // arm_q blanks edge detection for the first cycle after reset so that a
    // button held through reset release only primes its registered copy.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
        cruise_ev  = arm_q & cruise_btn & ~cruise_q;
        set_ev     = arm_q & set_btn & ~set_q;
        resume_ev  = RESUME_EN & arm_q & resume_btn & ~resume_q;
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        valid_d  = valid_q;
        enable_d = 1'b0;
        mode_d   = mode_q;

        case (state_q)
            ST_OFF: begin
                if (cruise_ev) state_d = ST_READY;
            end
            ST_READY: begin
                if (cruise_ev) begin
                    state_d  = ST_OFF;
                    target_d = 3'd0;
                    valid_d  = 1'b0;
                end else if (brake) begin
                    state_d = ST_READY;
                end else if (set_ev) begin
                    state_d  = ST_CRUISE;
                    target_d = speed;
                    valid_d  = 1'b1;
                end
            end
            ST_CRUISE: begin
                if (cruise_ev) begin
                    state_d  = ST_OFF;
                    target_d = 3'd0;
                    valid_d  = 1'b0;
                end else if (brake) begin
                    // Without resume support the held target can never be re-engaged.
                    state_d = ST_STANDBY;
                    valid_d = RESUME_EN ? valid_q : 1'b0;
                end else begin
                    if (set_ev) begin
                        target_d = speed;
                    end else if (tick) begin
                        if (accel && !coast && target_q != 3'd7)
                            target_d = target_q + 3'd1;
                        else if (coast && !accel && target_q != 3'd0)
                            target_d = target_q - 3'd1;
                    end
                    // Compare against the target as it stood in the tick cycle.
                    if (tick && speed != target_q) begin
                        enable_d = 1'b1;
                        mode_d   = (speed < target_q);
                    end
                end
            end
            ST_STANDBY: begin
                if (cruise_ev) begin
                    state_d  = ST_OFF;
                    target_d = 3'd0;
                    valid_d  = 1'b0;
                end else if (brake) begin
                    state_d = ST_STANDBY;
                end else if (set_ev) begin
                    state_d  = ST_CRUISE;
                    target_d = speed;
                    valid_d  = 1'b1;
                end else if (resume_ev && valid_q) begin
                    state_d = ST_CRUISE;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_OFF;
            target_q   <= 3'd0;
            valid_q    <= 1'b0;
            enable_q   <= 1'b0;
            mode_q     <= 1'b0;
            tick_cnt_q <= 8'd0;
            cruise_q   <= 1'b0;
            set_q      <= 1'b0;
            resume_q   <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            valid_q    <= valid_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            tick_cnt_q <= tick_cnt_d;
            cruise_q   <= cruise_btn;
            set_q      <= set_btn;
            resume_q   <= resume_btn;
            arm_q      <= 1'b1;
        end
    end

    assign enable = enable_q;
    assign mode   = mode_q;
    assign state  = state_q;
    assign target = target_q;

endmodule

// File: tb/tb_cruise_ctrl_fsm.sv
// Directed scoreboard bench for cruise_ctrl_fsm: expected enable pulses (mode + cycle index)
// are queued as stimulus is driven and matched by a negedge monitor.
module tb_cruise_ctrl_fsm;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cruise_btn, set_btn, resume_btn, accel, coast, brake;
    logic [2:0] speed;
    logic       enable, mode;
    logic [1:0] state;
    logic [2:0] target;

    logic [15:0] pe;
    logic [16:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    cruise_ctrl_fsm #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .cruise_btn (cruise_btn),
        .set_btn    (set_btn),
        .resume_btn (resume_btn),
        .accel      (accel),
        .coast      (coast),
        .brake      (brake),
        .speed      (speed),
        .enable     (enable),
        .mode       (mode),
        .state      (state),
        .target     (target)
    );

    // clock / reset-relative cycle index
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) pe <= 16'd0;
        else       pe <= pe + 16'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard monitor: every enable pulse must match the queue head
    always @(negedge clk) begin
        if (enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("en_unexpected", 32'(enable), 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check_eq("en_pulse", {15'd0, mode, pe}, {15'd0, e});
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which);
        case (which)
            0: cruise_btn = 1'b1;
            1: set_btn    = 1'b1;
            default: resume_btn = 1'b1;
        endcase
        step(1);
        cruise_btn = 1'b0;
        set_btn    = 1'b0;
        resume_btn = 1'b0;
        step(1);
    endtask

    // Land in the cycle whose rising edge is a tick.
    task automatic align_tick();
        for (int i = 0; i < 4 * TICK_DIV && (pe % TICK_DIV) != TICK_DIV - 1; i++)
            @(negedge clk);
        check_eq("align_tick", 32'(pe % TICK_DIV), 32'(TICK_DIV - 1));
    endtask

    task automatic after_tick();
        align_tick();
        step(1);
    endtask

    task automatic push_pulse(input logic m, input logic [15:0] idx);
        exp_q.push_back({m, idx});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t;
        reset = 1'b1;
        cruise_btn = 1'b1;
        set_btn = 1'b0; resume_btn = 1'b0;
        accel = 1'b0; coast = 1'b0; brake = 1'b0;
        speed = 3'd0;
        step(2);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_enable", 32'(enable), 32'd0);
        check_eq("rst_mode", 32'(mode), 32'd0);
        check_eq("rst_target", 32'(target), 32'd0);

        // cruise_btn held through reset release must not count as an edge
        reset = 1'b0;
        step(3);
        check_eq("held_btn_state", 32'(state), 32'd0);
        cruise_btn = 1'b0;
        step(1);

        // bring-up: OFF -> READY -> CRUISE at speed 3
        press(0);
        check_eq("ready_state", 32'(state), 32'b01);
        speed = 3'd3;
        press(1);
        check_eq("set_state", 32'(state), 32'b10);
        check_eq("set_target", 32'(target), 32'd3);
        step(2 * TICK_DIV);
        check_eq("set_enable_idle", 32'(enable), 32'd0);

        // accel for 3 ticks: 3 -> 6, pulses on ticks 2 and 3
        align_tick();
        t = pe + 16'd1;
        accel = 1'b1;
        push_pulse(1'b1, t + 16'(TICK_DIV));
        push_pulse(1'b1, t + 16'(2 * TICK_DIV));
        step(1 + 2 * TICK_DIV);
        accel = 1'b0;
        speed = 3'd6;
        check_eq("accel_target", 32'(target), 32'd6);
        step(2);
        check_eq("accel_mode_hold", 32'(mode), 32'd1);
        check_eq("accel_en_low", 32'(enable), 32'd0);

        // recapture target 1, coast 4 ticks: saturate at 0, down pulses
        after_tick();
        speed = 3'd1;
        press(1);
        check_eq("recap_target", 32'(target), 32'd1);
        align_tick();
        t = pe + 16'd1;
        coast = 1'b1;
        push_pulse(1'b0, t + 16'(TICK_DIV));
        push_pulse(1'b0, t + 16'(2 * TICK_DIV));
        push_pulse(1'b0, t + 16'(3 * TICK_DIV));
        step(1 + 3 * TICK_DIV);
        coast = 1'b0;
        speed = 3'd0;
        check_eq("coast_target", 32'(target), 32'd0);
        step(2);
        check_eq("coast_mode_hold", 32'(mode), 32'd0);

        // accel and coast together leave the target alone
        after_tick();
        speed = 3'd3;
        press(1);
        align_tick();
        accel = 1'b1;
        coast = 1'b1;
        step(1 + TICK_DIV);
        accel = 1'b0;
        coast = 1'b0;
        check_eq("both_target", 32'(target), 32'd3);

        // target 5, brake -> STANDBY, then resume
        after_tick();
        speed = 3'd5;
        press(1);
        check_eq("t5_target", 32'(target), 32'd5);
        brake = 1'b1;
        step(1);
        check_eq("brake_state", 32'(state), 32'b11);
        check_eq("brake_enable", 32'(enable), 32'd0);
        brake = 1'b0;
        step(1);
        check_eq("brake_target", 32'(target), 32'd5);
        press(2);
`ifdef CRUISE_RESUME_EN
        check_eq("resume_state", 32'(state), 32'b10);
`else
        check_eq("resume_state", 32'(state), 32'b11);
`endif
        check_eq("resume_target", 32'(target), 32'd5);
        press(1);
        check_eq("cruise_again", 32'(state), 32'b10);

        // brake in the tick cycle suppresses a due pulse
        align_tick();
        speed = 3'd2;
        brake = 1'b1;
        step(1);
        check_eq("brake_tick_state", 32'(state), 32'b11);
        check_eq("brake_tick_en", 32'(enable), 32'd0);
        brake = 1'b0;
        speed = 3'd5;
        step(2);
        press(1);
        check_eq("standby_set_state", 32'(state), 32'b10);
        check_eq("standby_set_target", 32'(target), 32'd5);

        // cruise_btn edge beats brake
        cruise_btn = 1'b1;
        brake = 1'b1;
        step(1);
        check_eq("off_state", 32'(state), 32'b00);
        check_eq("off_target", 32'(target), 32'd0);
        cruise_btn = 1'b0;
        brake = 1'b0;
        step(1);

        // reset in the tick cycle aborts a pending pulse
        press(0);
        press(1);
        check_eq("pre_rst_state", 32'(state), 32'b10);
        align_tick();
        speed = 3'd2;
        #1 reset = 1'b1;
        step(1);
        check_eq("abort_enable", 32'(enable), 32'd0);
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_target", 32'(target), 32'd0);
        check_eq("abort_mode", 32'(mode), 32'd0);
        reset = 1'b0;
        speed = 3'd5;
        step(3 * TICK_DIV);
        check_eq("post_rst_off", 32'(state), 32'd0);
        check_eq("post_rst_enable", 32'(enable), 32'd0);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
